// File: rtl/alu_op_sequencer_pkg.sv
// Shared ALU op codes, RV32I opcode constants, branch kinds and sequencer FSM states.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package alu_op_sequencer_pkg;

    // ALU operation codes; 0100 and 1011-1111 are never produced.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_SLT  = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_SLTU = 4'b1010
    } alu_op_e;

    // RV32I major opcodes recognised by the decoder.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct7 values: base encoding and the alternate (SUB/SRA) encoding.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    // Branch kinds, encoded as their funct3 values.
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_kind_e;

    // Shared funct3 -> ALU op mapping; alt picks SUB for 000 and SRA for 101.
    function automatic alu_op_e funct3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch resolution from the ALU flags produced by SUB (signed) or SLTU (unsigned).
    function automatic logic resolve_taken(input br_kind_e kind, input logic z,
                                           input logic n, input logic v);
        logic taken;
        case (kind)
            BR_EQ:   taken = z;
            BR_NE:   taken = !z;
            BR_LT:   taken = n ^ v;
            BR_GE:   taken = !(n ^ v);
            BR_LTU:  taken = n;
            BR_GEU:  taken = !n;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction-in / result-out handshake bundle plus the ALU control and flag signals.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the instruction side, out_valid/out_ready on the result side.
interface alu_op_sequencer_if #(
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_src_imm;
    logic              alu_z;
    logic              alu_n;
    logic              alu_v;
    logic              out_valid;
    logic              out_ready;
    logic              is_branch;
    logic              branch_taken;
    logic              illegal;

    // Producer/consumer side: issues instructions, returns ALU flags, accepts results.
    modport master (
        output in_valid, instr, alu_z, alu_n, alu_v, out_ready,
        input  in_ready, alu_ctrl, alu_src_imm, out_valid, is_branch, branch_taken, illegal
    );

    // Sequencer side.
    modport slave (
        input  in_valid, instr, alu_z, alu_n, alu_v, out_ready,
        output in_ready, alu_ctrl, alu_src_imm, out_valid, is_branch, branch_taken, illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode: instruction word -> ALU op, operand select, branch kind, illegal.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the outputs are captured.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
(
    input  logic [31:0] instr_i,
    output alu_op_e     alu_ctrl_o,
    output logic        alu_src_imm_o,
    output logic        is_branch_o,
    output br_kind_e    br_kind_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register numbers and immediate fields do not affect the ALU op.
    logic unused_fields;
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    // Opcode/funct decode; any illegal encoding collapses to ADD, rs2 operand, non-branch.
    always_comb begin
        alu_ctrl_o    = ALU_ADD;
        alu_src_imm_o = 1'b0;
        is_branch_o   = 1'b0;
        br_kind_o     = BR_EQ;
        illegal_o     = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    alu_ctrl_o = funct3_to_op(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    alu_ctrl_o = funct3_to_op(funct3, 1'b1);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                alu_src_imm_o = 1'b1;
                case (funct3)
                    3'b001: begin
                        if (funct7 == F7_BASE) alu_ctrl_o = ALU_SLL;
                        else                   illegal_o  = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     alu_ctrl_o = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_ctrl_o = ALU_SRA;
                        else                       illegal_o  = 1'b1;
                    end
                    // funct7 bits are immediate here; there is no SUBI.
                    default: alu_ctrl_o = funct3_to_op(funct3, 1'b0);
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LUI: begin
                // Address / link / upper-immediate computations all use ADD with the immediate.
                alu_ctrl_o    = ALU_ADD;
                alu_src_imm_o = 1'b1;
            end
            OPC_BRANCH: begin
                is_branch_o = 1'b1;
                case (funct3)
                    3'b000: begin alu_ctrl_o = ALU_SUB;  br_kind_o = BR_EQ;  end
                    3'b001: begin alu_ctrl_o = ALU_SUB;  br_kind_o = BR_NE;  end
                    3'b100: begin alu_ctrl_o = ALU_SUB;  br_kind_o = BR_LT;  end
                    3'b101: begin alu_ctrl_o = ALU_SUB;  br_kind_o = BR_GE;  end
                    3'b110: begin alu_ctrl_o = ALU_SLTU; br_kind_o = BR_LTU; end
                    3'b111: begin alu_ctrl_o = ALU_SLTU; br_kind_o = BR_GEU; end
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase

        if (illegal_o) begin
            alu_ctrl_o    = ALU_ADD;
            alu_src_imm_o = 1'b0;
            is_branch_o   = 1'b0;
            br_kind_o     = BR_EQ;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one RV32I instruction, drives the ALU op for one cycle, resolves branches from the flags.
// Latency: result valid 2 cycles after acceptance (legal) or 1 cycle (illegal); max 1 instr per 3 cycles.
// Backpressure: in_ready only in IDLE; result held with out_valid until out_ready, then back to IDLE.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int CTRL_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_op_sequencer_if.slave   bus
);

    seq_state_e state_q, state_d;
    alu_op_e    alu_ctrl_q, alu_ctrl_d;
    logic       alu_src_imm_q, alu_src_imm_d;
    logic       is_branch_q, is_branch_d;
    br_kind_e   br_kind_q, br_kind_d;
    logic       taken_q, taken_d;
    logic       illegal_q, illegal_d;

    alu_op_e    dec_ctrl;
    logic       dec_src_imm;
    logic       dec_is_branch;
    br_kind_e   dec_br_kind;
    logic       dec_illegal;

    alu_op_decode u_decode (
        .instr_i       (bus.instr),
        .alu_ctrl_o    (dec_ctrl),
        .alu_src_imm_o (dec_src_imm),
        .is_branch_o   (dec_is_branch),
        .br_kind_o     (dec_br_kind),
        .illegal_o     (dec_illegal)
    );

    // State and result registers; reset wins over every transition and drops any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            alu_ctrl_q    <= ALU_ADD;
            alu_src_imm_q <= 1'b0;
            is_branch_q   <= 1'b0;
            br_kind_q     <= BR_EQ;
            taken_q       <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_ctrl_q    <= alu_ctrl_d;
            alu_src_imm_q <= alu_src_imm_d;
            is_branch_q   <= is_branch_d;
            br_kind_q     <= br_kind_d;
            taken_q       <= taken_d;
            illegal_q     <= illegal_d;
        end
    end

    // Next-state logic: capture decode at acceptance, resolve flags leaving EXEC, clear on handoff.
    always_comb begin
        state_d       = state_q;
        alu_ctrl_d    = alu_ctrl_q;
        alu_src_imm_d = alu_src_imm_q;
        is_branch_d   = is_branch_q;
        br_kind_d     = br_kind_q;
        taken_d       = taken_q;
        illegal_d     = illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    // The decoder already forces ADD/rs2/non-branch for illegal words.
                    alu_ctrl_d    = dec_ctrl;
                    alu_src_imm_d = dec_src_imm;
                    is_branch_d   = dec_is_branch;
                    br_kind_d     = dec_br_kind;
                    taken_d       = 1'b0;
                    illegal_d     = dec_illegal;
                    // Illegal words skip the ALU cycle entirely.
                    state_d       = dec_illegal ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                if (is_branch_q) begin
                    taken_d = resolve_taken(br_kind_q, bus.alu_z, bus.alu_n, bus.alu_v);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    // Returning to IDLE rather than accepting here bounds throughput to 1 per 3 cycles.
                    state_d       = ST_IDLE;
                    alu_ctrl_d    = ALU_ADD;
                    alu_src_imm_d = 1'b0;
                    is_branch_d   = 1'b0;
                    br_kind_d     = BR_EQ;
                    taken_d       = 1'b0;
                    illegal_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready     = (state_q == ST_IDLE);
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.alu_ctrl     = CTRL_W'(alu_ctrl_q);
    assign bus.alu_src_imm  = alu_src_imm_q;
    assign bus.is_branch    = is_branch_q;
    assign bus.branch_taken = taken_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven bench for alu_op_sequencer plus hand-written stall/reset/throughput sequences.
// Latency: checks EXEC one cycle and DONE two cycles after acceptance (one for illegal words).
// Backpressure: exercises out_ready held low in DONE and in_valid held high across back-to-back results.
module tb_alu_op_sequencer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic        z;
        logic        n;
        logic        v;
        logic [3:0]  ctrl;
        logic        src;
        logic        br;
        logic        tk;
        logic        ill;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t vecs[$];

    alu_op_sequencer_if #(.CTRL_W(4)) bus ();

    alu_op_sequencer #(.CTRL_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check1({tag, " in_ready"},     bus.in_ready,     H);
        check1({tag, " out_valid"},    bus.out_valid,    L);
        check4({tag, " alu_ctrl"},     bus.alu_ctrl,     4'b0000);
        check1({tag, " alu_src_imm"},  bus.alu_src_imm,  L);
        check1({tag, " is_branch"},    bus.is_branch,    L);
        check1({tag, " branch_taken"}, bus.branch_taken, L);
        check1({tag, " illegal"},      bus.illegal,      L);
    endtask

    task automatic add(input logic [31:0] instr, input logic z, input logic n, input logic v,
                       input logic [3:0] ctrl, input logic src, input logic br,
                       input logic tk, input logic ill);
        vec_t e;
        e.instr = instr; e.z = z; e.n = n; e.v = v;
        e.ctrl = ctrl; e.src = src; e.br = br; e.tk = tk; e.ill = ill;
        vecs.push_back(e);
    endtask

    // Issue one instruction at a negedge; leaves the DUT in DONE with out_ready=0.
    task automatic issue(input vec_t e, input string tag);
        check1({tag, " idle in_ready"}, bus.in_ready, H);
        bus.instr    = e.instr;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.instr    = 32'h0000_0000;   // illegal word: must not affect the captured result
        if (!e.ill) begin
            check1({tag, " exec in_ready"},  bus.in_ready,    L);
            check1({tag, " exec out_valid"}, bus.out_valid,   L);
            check4({tag, " exec alu_ctrl"},  bus.alu_ctrl,    e.ctrl);
            check1({tag, " exec src_imm"},   bus.alu_src_imm, e.src);
            bus.alu_z = e.z;
            bus.alu_n = e.n;
            bus.alu_v = e.v;
            @(negedge clk);
            bus.alu_z = ~e.z;            // flags outside EXEC must be ignored
            bus.alu_n = ~e.n;
            bus.alu_v = ~e.v;
        end
        check1({tag, " done out_valid"}, bus.out_valid,    H);
        check1({tag, " done in_ready"},  bus.in_ready,     L);
        check4({tag, " done alu_ctrl"},  bus.alu_ctrl,     e.ctrl);
        check1({tag, " done src_imm"},   bus.alu_src_imm,  e.src);
        check1({tag, " done is_branch"}, bus.is_branch,    e.br);
        check1({tag, " done taken"},     bus.branch_taken, e.tk);
        check1({tag, " done illegal"},   bus.illegal,      e.ill);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_idle({tag, " after ack"});
    endtask

    initial begin
        vec_t e;
        int   accepts;

        total = 0;
        bad   = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.instr     = 32'h0;
        bus.alu_z     = 1'b0;
        bus.alu_n     = 1'b0;
        bus.alu_v     = 1'b0;
        bus.out_ready = 1'b0;

        //   instr         z  n  v  ctrl     src br tk ill
        add(32'h40B50533, L, L, L, 4'b0001, L, L, L, L);  // sub
        add(32'h00B50533, L, L, L, 4'b0000, L, L, L, L);  // add
        add(32'h00B57533, L, L, L, 4'b0010, L, L, L, L);  // and
        add(32'h00B56533, L, L, L, 4'b0011, L, L, L, L);  // or
        add(32'h00B51533, L, L, L, 4'b0111, L, L, L, L);  // sll
        add(32'h40B55533, L, L, L, 4'b1001, L, L, L, L);  // sra
        add(32'h00B53533, L, L, L, 4'b1010, L, L, L, L);  // sltu
        add(32'h02B50533, L, L, L, 4'b0000, L, L, L, H);  // funct7 0000001
        add(32'h40B51533, L, L, L, 4'b0000, L, L, L, H);  // funct7 0100000 with sll
        add(32'h00550513, L, L, L, 4'b0000, H, L, L, L);  // addi
        add(32'h00552513, L, L, L, 4'b0101, H, L, L, L);  // slti
        add(32'h00554513, L, L, L, 4'b0110, H, L, L, L);  // xori
        add(32'h00355513, L, L, L, 4'b1000, H, L, L, L);  // srli
        add(32'h40355513, L, L, L, 4'b1001, H, L, L, L);  // srai
        add(32'h40351513, L, L, L, 4'b0000, L, L, L, H);  // slli with funct7 0100000
        add(32'h0005A503, L, L, L, 4'b0000, H, L, L, L);  // lw
        add(32'h00A5A023, L, L, L, 4'b0000, H, L, L, L);  // sw
        add(32'h12345537, L, L, L, 4'b0000, H, L, L, L);  // lui
        add(32'h0000006F, L, L, L, 4'b0000, H, L, L, L);  // jal
        add(32'h00B50463, H, L, L, 4'b0001, L, H, H, L);  // beq z=1
        add(32'h00B50463, L, L, L, 4'b0001, L, H, L, L);  // beq z=0
        add(32'h00B51463, L, L, L, 4'b0001, L, H, H, L);  // bne z=0
        add(32'h00B56463, L, H, L, 4'b1010, L, H, H, L);  // bltu n=1
        add(32'h00B54463, L, H, H, 4'b0001, L, H, L, L);  // blt n=1 v=1
        add(32'h00B55463, L, H, L, 4'b0001, L, H, L, L);  // bge n=1 v=0
        add(32'h00B57463, L, L, L, 4'b1010, L, H, H, L);  // bgeu n=0
        add(32'h00B52463, L, L, L, 4'b0000, L, L, L, H);  // branch funct3 010
        add(32'h00000000, L, L, L, 4'b0000, L, L, L, H);  // opcode 0000000
        add(32'h00000073, L, L, L, 4'b0000, L, L, L, H);  // ecall opcode

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");

        foreach (vecs[i]) begin
            issue(vecs[i], $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        // Stall in DONE for 5 cycles with a competing instruction and flipping flags.
        e = vecs[22];   // bltu, taken
        issue(e, "stall");
        bus.instr    = 32'h40B50533;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.alu_n = c[0];
            @(negedge clk);
            check1($sformatf("stall%0d out_valid", c), bus.out_valid,    H);
            check1($sformatf("stall%0d in_ready", c),  bus.in_ready,     L);
            check4($sformatf("stall%0d alu_ctrl", c),  bus.alu_ctrl,     4'b1010);
            check1($sformatf("stall%0d taken", c),     bus.branch_taken, H);
            check1($sformatf("stall%0d is_branch", c), bus.is_branch,    H);
        end
        bus.in_valid = 1'b0;
        release_result("stall");

        // Reset asserted during EXEC.
        bus.instr    = 32'h00B56463;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check1("rst_exec pre is_branch", bus.is_branch, H);
        reset = 1'b1;
        bus.alu_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("rst_exec");
        @(negedge clk);
        check_idle("rst_exec hold");

        // Reset asserted in DONE with the result unacknowledged.
        issue(vecs[19], "rst_done");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("rst_done");

        // Back-to-back: in_valid and out_ready held high for 9 cycles -> exactly 3 acceptances.
        accepts = 0;
        bus.instr     = 32'h00B50533;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (bus.in_ready) accepts++;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (accepts != 3) begin
            bad++;
            $display("FAIL throughput: got %0d accepts expected 3", accepts);
        end
        check_idle("throughput end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
